stmt_lowerer_seq_sel_encoder: RTL
=================================

Name: stmt_lowerer_seq_sel_encoder

Overview:
- Sequential select encoder: the producing end of the `sel` → mux-output case-select interface.
- Captures a request vector through a valid/ready handshake.
- Emits one encoded `sel` per set request bit, in round-robin order, through a second valid/ready handshake. A downstream case/casez mux consumes it.
- Serves as convert-flow test data for `always_ff` lowering: enum FSM, casez/if-chain priority, `for` loop search, saturating counter.

Parameters:
- N_REQ, 4: number of request lines; legal range 2..16.
- SEL_W, $clog2(N_REQ): encoded select width; localparam, not overridable.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request vector; sampled on input handshake.
- in_valid  input  1  req is valid.
- in_ready  output  1  block accepts req; equals (state==IDLE) && !rst.
- sel  output  SEL_W  encoded granted index; registered.
- sel_onehot  output  N_REQ  one-hot of sel; registered; 0 when sel_valid=0.
- sel_valid  output  1  sel/sel_onehot valid.
- sel_ready  input  1  consumer accepts sel.
- drop_cnt  output  CNT_W  saturating count of all-zero captures.

Behaviour:
- Reset values (sync rst high at an edge): state=IDLE, pend=0, ptr=N_REQ-1, sel=0, sel_onehot=0, sel_valid=0, drop_cnt=0. Reset overrides every other event in the same cycle, including mid-burst and mid-HOLD; the pending vector is discarded.
- FSM states: IDLE, SCAN, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready: pend<=req, state<=SCAN. Otherwise stay.
- SCAN (one cycle, in_ready=0):
  - pend==0: drop_cnt<=drop_cnt+1, saturating at 2^CNT_W-1; state<=IDLE.
  - Otherwise pick g = first set bit of pend searching ptr+1, ptr+2, … modulo N_REQ (wrap-around). Load sel<=g, sel_onehot<=1<<g, sel_valid<=1, state<=HOLD.
- HOLD: sel, sel_onehot and sel_valid hold stable while sel_ready=0 (no limit on stall). On sel_ready=1:
  - ptr<=g, pend[g]<=0, sel_valid<=0, sel_onehot<=0.
  - state<=SCAN if the remaining pend is nonzero, else IDLE.
  - sel keeps its last value after sel_valid drops.
- Latency:
  - Input handshake at cycle T → sel_valid=1 from T+2.
  - Output handshake at H → next sel_valid from H+2, or in_ready=1 at H+1 when no requests remain.
- in_valid is ignored outside IDLE. req is sampled only on handshake; later changes do not affect the burst.
- ptr persists across bursts, giving fairness across captures.
- Arithmetic: the index wrap uses an explicit compare-and-subtract on SEL_W+1 bits; no modulo operator. For non-power-of-2 N_REQ, sel never exceeds N_REQ-1.

Decomposition:
- Package stmt_lowerer_pkg holds: state enum typedef (IDLE/SCAN/HOLD, 2-bit), default N_REQ and CNT_W constants, and a function onehot_of(idx).
- One sub-module, stmt_lowerer_rr_pick: purely combinational.
  - Inputs: pend, ptr. Outputs: found, g.
  - Implemented as a rotate, then a `for`-loop priority search, then an un-rotate.
- The top module holds the FSM, registers and counter.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 → sel_valid=0, sel=0, sel_onehot=0, drop_cnt=0; in_ready=0 during rst, 1 in the first cycle after.
- Burst, sel_ready=1 constant: req=4'b0101 handshake at T → sel=0 / onehot 0001 at T+2; sel=2 / onehot 0100 at T+4; in_ready=1 at T+5; ptr=2.
- Round-robin wrap: with ptr=2, req=4'b1111 captured → sel sequence 3,0,1,2 on cycles T+2, T+4, T+6, T+8; then IDLE.
- Backpressure: req=4'b1000, sel_ready=0 for 5 cycles after sel_valid rises → sel=3 and sel_valid=1 stable all 5 cycles, in_ready=0; sel_ready=1 → sel_valid=0 next cycle, in_ready=1 the cycle after the handshake.
- Zero request and saturation:
  - req=4'b0000 captured → no sel_valid ever; drop_cnt 0→1 at T+2; in_ready=1 at T+2.
  - 300 consecutive zero captures → drop_cnt=255.
- Reset mid-operation: rst=1 during HOLD with sel=1 and pend=4'b0110 → next cycle sel_valid=0, state IDLE, ptr=3. A subsequent req=4'b0011 yields sel=0 first.

Source files
------------

// File: rtl/stmt_lowerer_pkg.sv
// Shared types and constants for the sequential select encoder.
// Holds the FSM state encoding and the one-hot helper used for sel_onehot.
package stmt_lowerer_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Sized for the widest legal request vector (16 lines).
  function automatic logic [15:0] onehot_of(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/stmt_lowerer_rr_pick.sv
// Round-robin picker: first set bit of pend starting just after ptr, with wrap.
// Latency: combinational; backpressure: none (pure function of its inputs).
module stmt_lowerer_rr_pick #(
  parameter int N_REQ = 4,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] g
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [SEL_W:0]   base;
  logic [SEL_W:0]   idx;
  logic [SEL_W-1:0] off;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    off   = '0;
    idx   = '0;
    g     = '0;
    base  = {1'b0, ptr} + (SEL_W+1)'(1);

    // rot[0] is the line right after ptr; base+i < 2*N_REQ so one subtract wraps it
    for (int i = 0; i < N_REQ; i++) begin
      idx = base + (SEL_W+1)'(i);
      if (idx >= N_EXT) idx = idx - N_EXT;
      rot[i] = pend[idx[SEL_W-1:0]];
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end

    idx = base + {1'b0, off};
    if (idx >= N_EXT) idx = idx - N_EXT;
    g = idx[SEL_W-1:0];
  end

endmodule

// File: rtl/stmt_lowerer_seq_sel_encoder.sv
// Captures a request vector and emits one encoded sel per set bit in round-robin order.
// Latency: capture -> sel_valid in 2 cycles; sel held stable while sel_ready is low, no new capture until drained.
module stmt_lowerer_seq_sel_encoder
  import stmt_lowerer_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] sel_onehot,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] pend_rem;
  logic [SEL_W-1:0] ptr;
  logic             found;
  logic [SEL_W-1:0] g;

  stmt_lowerer_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .pend  (pend),
    .ptr   (ptr),
    .found (found),
    .g     (g)
  );

  // sel_onehot marks the line being granted while in HOLD
  assign pend_rem = pend & ~sel_onehot;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SCAN;
      SCAN: state_nxt = found ? HOLD : IDLE;
      HOLD: if (sel_ready) state_nxt = (pend_rem != '0) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      ptr        <= SEL_W'(N_REQ-1);
      sel        <= '0;
      sel_onehot <= '0;
      sel_valid  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) pend <= req;
        SCAN: begin
          if (!found) begin
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
          end else begin
            sel        <= g;
            sel_onehot <= N_REQ'(onehot_of(4'(g)));
            sel_valid  <= 1'b1;
          end
        end
        HOLD: if (sel_ready) begin
          ptr        <= sel;
          pend       <= pend_rem;
          sel_valid  <= 1'b0;
          sel_onehot <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
